mem_write_dispatch: RTL

Store-side counterpart of the CPU memory-map decode.
- Takes one CPU store request at a time and decodes the 16-bit address.
- Serial-port data addresses: queues the low byte into that port's transmit queue.
- Other non-status addresses: runs a timed SRAM write cycle.
- Sits between the CPU memory stage and the SRAM pins / two UART transmitters; answers each store with a one-cycle acknowledge.

---
 rtl/mem_map_pkg.sv | 44 ++++
 rtl/serial_tx_queue.sv | 63 ++++++
 rtl/mem_write_dispatch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the CPU load/store decode paths.
// Holds the serial-port register addresses, the 3-bit target index and the
// store-side FSM state type. Both decode directions import this package.
package mem_map_pkg;

  // Serial port register addresses (status registers are read-only).
  localparam logic [15:0] MM_SERIAL1_DATA_ADDR  = 16'hBF00;
  localparam logic [15:0] MM_SERIAL1_STATE_ADDR = 16'hBF01;
  localparam logic [15:0] MM_SERIAL2_DATA_ADDR  = 16'hBF02;
  localparam logic [15:0] MM_SERIAL2_STATE_ADDR = 16'hBF03;

  // Target index: bit1 = serial, bit2 = port 2, bit0 = status register.
  localparam logic [2:0] TGT_RAM        = 3'b000;
  localparam logic [2:0] TGT_SER1_DATA  = 3'b010;
  localparam logic [2:0] TGT_SER1_STATE = 3'b011;
  localparam logic [2:0] TGT_SER2_DATA  = 3'b110;
  localparam logic [2:0] TGT_SER2_STATE = 3'b111;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WR_ACK
  } wrState_e;

  // Map an address to its target index; anything not a serial register is RAM.
  function automatic logic [2:0] decodeTarget(
    input logic [15:0] addr,
    input logic [15:0] s1Data,
    input logic [15:0] s1State,
    input logic [15:0] s2Data,
    input logic [15:0] s2State
  );
    logic [2:0] tgt;
    tgt = TGT_RAM;
    if (addr == s1Data)       tgt = TGT_SER1_DATA;
    else if (addr == s1State) tgt = TGT_SER1_STATE;
    else if (addr == s2Data)  tgt = TGT_SER2_DATA;
    else if (addr == s2State) tgt = TGT_SER2_STATE;
    return tgt;
  endfunction

endpackage

// File: rtl/serial_tx_queue.sv
// Byte transmit queue feeding one UART transmitter, with its launch strobe.
// Latency: a byte pushed into an empty queue is strobed out two edges later at
// the earliest. Backpressure: full blocks pushes; txBusy and a guard cycle after
// each strobe block pops.
// Ports: clk/rst; pushVld/pushDat (push, ignored when full); full;
//        txBusy (transmitter shifting); txData/txStart (launch); txIdle (status).
module serial_tx_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pushVld,
  input  logic [7:0] pushDat,
  output logic       full,
  input  logic       txBusy,
  output logic [7:0] txData,
  output logic       txStart,
  output logic       txIdle
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          doPush;
  logic          popEn;

  assign full   = (count == FULL_CNT);
  assign doPush = pushVld && !full;
  // A strobe this cycle blocks the next pop: the transmitter only raises
  // txBusy one cycle after it sees txStart.
  assign popEn  = (count != '0) && !txBusy && !txStart;
  assign txIdle = (count == '0) && !txBusy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      txStart <= 1'b0;
      txData  <= 8'h00;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushDat;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (popEn) begin
        rdPtr  <= rdPtr + 1'b1;
        txData <= mem[rdPtr];
      end
      txStart <= popEn;
      case ({doPush, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_write_dispatch.sv
// Store-side address decode: routes CPU stores to SRAM or a serial TX queue.
// Latency: serial/status stores ack the next cycle; SRAM stores ack after
// WE_CYCLES+3 cycles. Backpressure: a store to a full queue is held unacked.
// Ports: clk/rst; wr_req/wr_addr/wr_data/wr_ack (CPU store handshake); busy;
//        ram_addr/ram_wdata/ram_wdata_oe/ram_we_n (SRAM pins);
//        uartN_tx_data/_start/_busy/_idle (transmitters 1 and 2).
module mem_write_dispatch
  import mem_map_pkg::*;
#(
  parameter int          WE_CYCLES          = 2,
  parameter int          TXQ_DEPTH          = 4,
  parameter logic [15:0] SERIAL1_DATA_ADDR  = MM_SERIAL1_DATA_ADDR,
  parameter logic [15:0] SERIAL1_STATE_ADDR = MM_SERIAL1_STATE_ADDR,
  parameter logic [15:0] SERIAL2_DATA_ADDR  = MM_SERIAL2_DATA_ADDR,
  parameter logic [15:0] SERIAL2_STATE_ADDR = MM_SERIAL2_STATE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        busy,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_wdata_oe,
  output logic        ram_we_n,
  output logic [7:0]  uart1_tx_data,
  output logic        uart1_tx_start,
  input  logic        uart1_tx_busy,
  output logic        uart1_tx_idle,
  output logic [7:0]  uart2_tx_data,
  output logic        uart2_tx_start,
  input  logic        uart2_tx_busy,
  output logic        uart2_tx_idle
);

  localparam int WCW = $clog2(WE_CYCLES + 1);

  wrState_e       state;
  logic [WCW-1:0] weCnt;
  logic [2:0]     target;
  logic           q1Full;
  logic           q2Full;
  logic           push1;
  logic           push2;

  assign target = decodeTarget(wr_addr, SERIAL1_DATA_ADDR, SERIAL1_STATE_ADDR,
                               SERIAL2_DATA_ADDR, SERIAL2_STATE_ADDR);

  // Pushes happen on the decode edge itself; the FSM moves to ACK alongside.
  assign push1 = (state == WR_IDLE) && wr_req && (target == TGT_SER1_DATA) && !q1Full;
  assign push2 = (state == WR_IDLE) && wr_req && (target == TGT_SER2_DATA) && !q2Full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WR_IDLE;
      weCnt        <= '0;
      wr_ack       <= 1'b0;
      busy         <= 1'b0;
      ram_addr     <= 16'h0000;
      ram_wdata    <= 16'h0000;
      ram_wdata_oe <= 1'b0;
      ram_we_n     <= 1'b1;
    end else begin
      wr_ack <= 1'b0;
      case (state)
        WR_IDLE: begin
          if (wr_req) begin
            case (target)
              TGT_SER1_DATA: begin
                if (!q1Full) begin
                  state  <= WR_ACK;
                  wr_ack <= 1'b1;
                end
              end
              TGT_SER2_DATA: begin
                if (!q2Full) begin
                  state  <= WR_ACK;
                  wr_ack <= 1'b1;
                end
              end
              // Status registers are read-only: swallow the write.
              TGT_SER1_STATE, TGT_SER2_STATE: begin
                state  <= WR_ACK;
                wr_ack <= 1'b1;
              end
              default: begin
                state        <= WR_SETUP;
                ram_addr     <= wr_addr;
                ram_wdata    <= wr_data;
                ram_wdata_oe <= 1'b1;
                ram_we_n     <= 1'b1;
                busy         <= 1'b1;
              end
            endcase
          end
        end
        WR_SETUP: begin
          state    <= WR_PULSE;
          ram_we_n <= 1'b0;
          weCnt    <= WCW'(1);
        end
        WR_PULSE: begin
          // weCnt counts cycles of ram_we_n low already elapsed.
          if (weCnt == WCW'(WE_CYCLES)) begin
            state    <= WR_HOLD;
            ram_we_n <= 1'b1;
          end else begin
            weCnt <= weCnt + 1'b1;
          end
        end
        WR_HOLD: begin
          state        <= WR_ACK;
          wr_ack       <= 1'b1;
          ram_wdata_oe <= 1'b0;
          busy         <= 1'b0;
        end
        // The CPU still holds wr_req during the ack cycle, so no decode here.
        WR_ACK: begin
          state <= WR_IDLE;
        end
        default: begin
          state <= WR_IDLE;
        end
      endcase
    end
  end

  serial_tx_queue #(.DEPTH(TXQ_DEPTH)) uTxq1 (
    .clk    (clk),
    .rst    (rst),
    .pushVld(push1),
    .pushDat(wr_data[7:0]),
    .full   (q1Full),
    .txBusy (uart1_tx_busy),
    .txData (uart1_tx_data),
    .txStart(uart1_tx_start),
    .txIdle (uart1_tx_idle)
  );

  serial_tx_queue #(.DEPTH(TXQ_DEPTH)) uTxq2 (
    .clk    (clk),
    .rst    (rst),
    .pushVld(push2),
    .pushDat(wr_data[7:0]),
    .full   (q2Full),
    .txBusy (uart2_tx_busy),
    .txData (uart2_tx_data),
    .txStart(uart2_tx_start),
    .txIdle (uart2_tx_idle)
  );

endmodule
